// File: rtl/axi_lite_cmd_sequencer.sv
// Single-outstanding AXI-lite command sequencer for the AIB AXI bridge master user interface.
// Optional watchdog enabled by defining AXI_SEQ_TIMEOUT_EN.
module axi_lite_cmd_sequencer #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_wr,
  input  logic                rst_wr_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic                busy,
  output logic [CNT_W-1:0]    wr_count,
  output logic [CNT_W-1:0]    rd_count,
  output logic [CNT_W-1:0]    err_count
);

  typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp, StRsp} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  write_q, write_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d;
  logic                  timeout;

`ifdef AXI_SEQ_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);
  logic [WdW-1:0] wd_q;
  logic           wd_active;

  assign wd_active = (state_q == StWrReq) || (state_q == StWrResp) ||
                     (state_q == StRdReq) || (state_q == StRdResp);
  assign timeout   = wd_active && (wd_q == WdLast);

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      wd_q <= '0;
    end else if (state_d != state_q) begin
      wd_q <= '0;
    end else if (wd_active) begin
      wd_q <= wd_q + WdW'(1);
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign m_awaddr  = addr_q;
  assign m_araddr  = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign busy      = (state_q != StIdle);
  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;
  assign err_count = err_cnt_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    cmd_ready = 1'b0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    rsp_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? StWrReq : StRdReq;
        end
      end
      StWrReq: begin
        // AW and W retire independently; leave once both have handshaken.
        m_awvalid = !aw_done_q;
        m_wvalid  = !w_done_q;
        aw_done_d = aw_done_q | m_awready;
        w_done_d  = w_done_q | m_wready;
        if (aw_done_d && w_done_d) state_d = StWrResp;
      end
      StWrResp: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          resp_d  = m_bresp;
          rdata_d = '0;
          state_d = StRsp;
        end
      end
      StRdReq: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = StRdResp;
      end
      StRdResp: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          rdata_d = m_rdata;
          resp_d  = m_rresp;
          state_d = StRsp;
        end
      end
      StRsp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
          if (write_q && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_W'(1);
          if (!write_q && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_W'(1);
          if (resp_q != 2'b00 && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // A handshake landing on the final watchdog cycle still wins.
    if (timeout && state_d == state_q) begin
      state_d = StRsp;
      resp_d  = 2'b11;
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_sequencer.sv
// Directed bench for axi_lite_cmd_sequencer with a response scoreboard (default build).
module tb_axi_lite_cmd_sequencer;

  localparam int unsigned CNT_W = 3;

  logic        clk_wr = 1'b0;
  logic        rst_wr_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic        busy;
  logic [CNT_W-1:0] wr_count, rd_count, err_count;

  typedef struct {
    logic        w;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } rsp_t;
  rsp_t sb[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk_wr = ~clk_wr;

  axi_lite_cmd_sequencer #(
    .ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy), .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
  );

  task automatic tick();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic w, input logic [31:0] rd, input logic [1:0] rr);
    rsp_t e;
    e.w = w; e.rdata = rd; e.resp = rr;
    sb.push_back(e);
  endtask

  // Present a command, wait (bounded) for acceptance, record its expected response.
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] erd, input logic [1:0] err);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    push(w, erd, err);
  endtask

  // Wait for a response, hold rsp_ready low for 'hold' cycles, then complete it.
  task automatic collect(input int hold);
    rsp_t e;
    int n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    chk("rsp_valid_wait", rsp_valid, 1);
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_write", rsp_write, e.w);
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_resp", rsp_resp, e.resp);
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("hold_rsp_valid", rsp_valid, 1);
        chk("hold_cmd_ready", cmd_ready, 0);
        chk("hold_rsp_rdata", rsp_rdata, e.rdata);
        chk("hold_rsp_resp", rsp_resp, e.resp);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] rd, input logic [1:0] rr);
    m_arready = 1'b1;
    send_cmd(1'b0, a, 32'h0, 4'h0, rd, rr);
    chk("rd_arvalid", m_arvalid, 1);
    chk("rd_araddr", m_araddr, a);
    tick();
    m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = rd; m_rresp = rr;
    tick();
    m_rvalid = 1'b0;
    collect(0);
  endtask

  initial begin
    rst_wr_n = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0; m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
    m_arready = 0; m_rdata = 0; m_rresp = 0; m_rvalid = 0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wr_count", wr_count, 0);
    rst_wr_n = 1'b1;

    // Zero-wait write.
    m_awready = 1; m_wready = 1;
    send_cmd(1'b1, 32'hA000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00);
    chk("w1_awvalid", m_awvalid, 1);
    chk("w1_wvalid", m_wvalid, 1);
    chk("w1_awaddr", m_awaddr, 32'hA000_0000);
    chk("w1_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("w1_wstrb", m_wstrb, 4'hF);
    tick();
    chk("w1_awvalid_drop", m_awvalid, 0);
    chk("w1_wvalid_drop", m_wvalid, 0);
    chk("w1_bready", m_bready, 1);
    m_awready = 0; m_wready = 0;
    m_bvalid = 1; m_bresp = 2'b00;
    tick();
    m_bvalid = 0;
    collect(0);
    chk("w1_wr_count", wr_count, 1);
    chk("w1_err_count", err_count, 0);

    // Write with W accepted 3 cycles after AW.
    m_awready = 1;
    send_cmd(1'b1, 32'hA000_0010, 32'h5555_AAAA, 4'h3, 32'h0, 2'b00);
    chk("w2_awvalid", m_awvalid, 1);
    chk("w2_wvalid", m_wvalid, 1);
    tick();
    m_awready = 0;
    chk("w2_awvalid_drop", m_awvalid, 0);
    for (int i = 0; i < 3; i++) begin
      chk("w2_wvalid_hold", m_wvalid, 1);
      chk("w2_wdata_hold", m_wdata, 32'h5555_AAAA);
      chk("w2_wstrb_hold", m_wstrb, 4'h3);
      chk("w2_no_bready", m_bready, 0);
      if (i == 2) m_wready = 1;
      tick();
    end
    m_wready = 0;
    chk("w2_wvalid_drop", m_wvalid, 0);
    chk("w2_bready", m_bready, 1);
    m_bvalid = 1; m_bresp = 2'b00;
    tick();
    m_bvalid = 0;
    collect(0);
    chk("w2_wr_count", wr_count, 2);

    // Read returning SLVERR, then a pending write held off by a stalled response.
    m_arready = 1;
    send_cmd(1'b0, 32'hA000_0000, 32'h0, 4'h0, 32'h1234_5678, 2'b10);
    chk("r1_arvalid", m_arvalid, 1);
    tick();
    m_arready = 0;
    chk("r1_rready", m_rready, 1);
    m_rvalid = 1; m_rdata = 32'h1234_5678; m_rresp = 2'b10;
    tick();
    m_rvalid = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'hA000_0004; cmd_wdata = 32'h11; cmd_wstrb = 4'h1;
    m_awready = 1; m_wready = 1;
    collect(5);
    chk("r1_rd_count", rd_count, 1);
    chk("r1_err_count", err_count, 1);
    chk("p_not_yet_busy", busy, 0);
    tick();
    cmd_valid = 0;
    push(1'b1, 32'h0, 2'b01);
    chk("p_busy", busy, 1);
    chk("p_awvalid", m_awvalid, 1);
    chk("p_awaddr", m_awaddr, 32'hA000_0004);
    tick();
    m_awready = 0; m_wready = 0;
    m_bvalid = 1; m_bresp = 2'b01;
    tick();
    m_bvalid = 0;
    collect(0);
    chk("p_wr_count", wr_count, 3);
    chk("p_err_count", err_count, 2);

    // Reset while waiting in RD_RESP.
    m_arready = 1;
    send_cmd(1'b0, 32'hA000_0008, 32'h0, 4'h0, 32'h0, 2'b00);
    tick();
    m_arready = 0;
    chk("rr_rready", m_rready, 1);
    rst_wr_n = 1'b0;
    tick();
    chk("rr_rready_clr", m_rready, 0);
    chk("rr_busy", busy, 0);
    chk("rr_araddr", m_araddr, 0);
    chk("rr_rsp_valid", rsp_valid, 0);
    chk("rr_wr_count", wr_count, 0);
    chk("rr_err_count", err_count, 0);
    chk("rr_cmd_ready", cmd_ready, 1);
    sb.delete();
    rst_wr_n = 1'b1;
    do_read(32'hA000_0000, 32'hCAFE_F00D, 2'b00);
    chk("rr_rd_count", rd_count, 1);
    chk("rr_err_after", err_count, 0);

    // Counter saturation at all-ones.
    for (int i = 0; i < 8; i++) do_read(32'hA000_0100 + 32'(i * 4), 32'(i), 2'b00);
    chk("sat_rd_count", rd_count, 3'h7);
    chk("sat_wr_count", wr_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
